// File: rtl/sum_bcd_pkg.sv
// ============================================================================
// sum_bcd_pkg
// Shared definitions for the sum binary-to-BCD converter:
//   - state_t        : converter FSM states (IDLE, SHIFT, DONE)
//   - BCD_ADJ_THRESH : digit value at/above which the add-3 correction applies
//   - BCD_ADJ_ADD    : the correction added to a digit before each shift
//   - cnt_width()    : width of a down-counter that must hold the value w
// ============================================================================
package sum_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    // Bits needed to hold the value w itself (the counter is loaded with w).
    function automatic int cnt_width(input int w);
        return (w < 1) ? 1 : $clog2(w + 1);
    endfunction

endpackage

// File: rtl/sum_bcd_converter_digit_adj.sv
// ============================================================================
// bcd_digit_adj
// Combinational double-dabble correction for one BCD digit:
//   adjusted = (digit >= 5) ? digit + 3 : digit
// Applied before the left shift so a digit that would become >= 10 after
// doubling carries correctly into the next digit instead.
// Ports:
//   digit     input  [3:0]  current scratch digit (0..9)
//   adjusted  output [3:0]  corrected digit (0..12, never carries out)
// ============================================================================
module bcd_digit_adj
    import sum_bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    always_comb begin
        if (digit >= BCD_ADJ_THRESH) begin
            adjusted = digit + BCD_ADJ_ADD;
        end else begin
            adjusted = digit;
        end
    end

endmodule

// File: rtl/sum_bcd_converter.sv
// ============================================================================
// sum_bcd_converter
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock,
// placed after the 8-bit operand adder so the 9-bit sum (carry as MSB) can be
// shown on decimal seven-segment displays.
//
// Parameters:
//   WIDTH   binary input width (default 9)
//   DIGITS  BCD digits produced (default 3); 2^WIDTH-1 must fit in DIGITS
//           decimal digits
// Ports:
//   CLK      input                 rising-edge clock
//   reset_n  input                 asynchronous active-low reset
//   start    input                 conversion request, accepted in IDLE or on
//                                  the edge leaving DONE (back-to-back)
//   bin      input  [WIDTH-1:0]    value to convert, captured on accept
//   busy     output                high from accept until the edge leaving DONE
//   done     output                one-cycle pulse, bcd/blank valid
//   bcd      output [4*DIGITS-1:0] digit i at [4i+3:4i], digit 0 = ones
//   blank    output [DIGITS-1:0]   leading-zero blank mask
//
// Build option: macro BCD_LEADING_BLANK_EN enables the leading-zero blank
// mask; without it blank is tied to 0 and no blanking logic exists.
//
// Latency: done is high in the cycle following the WIDTH-th edge after the
// accepting edge. All outputs are registered.
// ============================================================================
module sum_bcd_converter
    import sum_bcd_pkg::*;
#(
    parameter int WIDTH  = 9,
    parameter int DIGITS = 3
) (
    input  logic                  CLK,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank
);

    localparam int CW = cnt_width(WIDTH);
    localparam int SW = 4 * DIGITS;

    state_t             state_reg;
    logic [WIDTH-1:0]   shift_reg;
    logic [SW-1:0]      scratch_reg;
    logic [CW-1:0]      count_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [SW-1:0]      bcd_reg;

    logic [SW-1:0]      adj_scratch;
    logic [SW-1:0]      scratch_next;
    logic               last_shift;

    // Per-digit add-3 correction; digits are corrected independently with no
    // carry between them.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_digit_adj u_adj (
                .digit    (scratch_reg[4*gi +: 4]),
                .adjusted (adj_scratch[4*gi +: 4])
            );
        end
    endgenerate

    // Corrected scratch shifted left, pulling in the next binary MSB.
    assign scratch_next = {adj_scratch[SW-2:0], shift_reg[WIDTH-1]};
    assign last_shift   = (state_reg == SHIFT) && (count_reg == CW'(1));

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            scratch_reg <= '0;
            count_reg   <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            bcd_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        shift_reg   <= bin;
                        scratch_reg <= '0;
                        count_reg   <= CW'(WIDTH);
                        busy_reg    <= 1'b1;
                        state_reg   <= SHIFT;
                    end
                end
                SHIFT: begin
                    shift_reg   <= {shift_reg[WIDTH-2:0], 1'b0};
                    scratch_reg <= scratch_next;
                    count_reg   <= count_reg - CW'(1);
                    // The final shift's result goes straight to the output
                    // register so bcd is valid in the same cycle as done.
                    if (last_shift) begin
                        bcd_reg   <= scratch_next;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    done_reg <= 1'b0;
                    // A request on the edge leaving DONE starts the next
                    // conversion immediately, keeping busy high.
                    if (start) begin
                        shift_reg   <= bin;
                        scratch_reg <= '0;
                        count_reg   <= CW'(WIDTH);
                        state_reg   <= SHIFT;
                    end else begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign bcd  = bcd_reg;

`ifdef BCD_LEADING_BLANK_EN
    logic [DIGITS-1:0] blank_reg;
    logic [DIGITS-1:0] blank_next;

    // Walk from the most significant digit down; a digit is blanked while it
    // and everything above it are zero. The ones digit always shows.
    always_comb begin
        logic zero_above;
        blank_next = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above    = zero_above && (scratch_next[4*i +: 4] == 4'd0);
            blank_next[i] = zero_above;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            blank_reg <= '0;
        end else if (last_shift) begin
            blank_reg <= blank_next;
        end
    end

    assign blank = blank_reg;
`else
    assign blank = '0;
`endif

endmodule

// File: tb/tb_sum_bcd_converter.sv
// ============================================================================
// tb_sum_bcd_converter
// Self-checking bench for sum_bcd_converter. Expected digits and blank masks
// come from decimal arithmetic on the input value.
// ============================================================================
module tb_sum_bcd_converter;

    localparam int WIDTH  = 9;
    localparam int DIGITS = 3;
    localparam int LAT    = WIDTH;

    logic                CLK;
    logic                reset_n;
    logic                start;
    logic [WIDTH-1:0]    bin;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd;
    logic [DIGITS-1:0]   blank;

    int compared   = 0;
    int mismatched = 0;

    sum_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .CLK     (CLK),
        .reset_n (reset_n),
        .start   (start),
        .bin     (bin),
        .busy    (busy),
        .done    (done),
        .bcd     (bcd),
        .blank   (blank)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: decimal digits of v, hundreds/tens/ones.
    function automatic logic [11:0] model_bcd(input int v);
        logic [3:0] h, t, o;
        h = 4'((v / 100) % 10);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    // Reference: a leading digit is blanked when the value has fewer digits.
    function automatic logic [2:0] model_blank(input int v);
`ifdef BCD_LEADING_BLANK_EN
        return {v < 100, v < 10, 1'b0};
`else
        return 3'b000;
`endif
    endfunction

    // Issue one request and wait (bounded) for done. lat = -1 on timeout.
    task automatic do_convert(input int v, output int lat,
                              output logic [11:0] got_bcd,
                              output logic [2:0] got_blank,
                              output logic got_busy);
        @(negedge CLK);
        start = 1'b1;
        bin   = WIDTH'(v);
        @(posedge CLK);
        #1;
        start = 1'b0;
        bin   = WIDTH'($urandom);
        lat = -1;
        got_bcd = 'x;
        got_blank = 'x;
        got_busy = 1'bx;
        for (int c = 1; c <= 30; c++) begin
            @(posedge CLK);
            #1;
            if (done === 1'b1) begin
                lat       = c;
                got_bcd   = bcd;
                got_blank = blank;
                got_busy  = busy;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        start   = 1'b0;
        bin     = '0;
        repeat (2) @(posedge CLK);
        #1;
        compared++;
        if ({busy, done, bcd, blank} !== '0) begin
            mismatched++;
            $display("FAIL reset_state: busy=%b done=%b bcd=%h blank=%b required all 0",
                     busy, done, bcd, blank);
        end
        @(negedge CLK);
        reset_n = 1'b1;
        @(posedge CLK);
        #1;
        $display("reset released: busy=%b done=%b bcd=%h blank=%b", busy, done, bcd, blank);
    endtask

    // Run one conversion and check latency, result, overlap and exit.
    task automatic test_value(input string name, input int v);
        int lat;
        logic [11:0] gb;
        logic [2:0]  gk;
        logic        gy;
        do_convert(v, lat, gb, gk, gy);
        compared++;
        if (lat != LAT) begin
            mismatched++;
            $display("FAIL %s_latency: bin=%0d latency=%0d required %0d", name, v, lat, LAT);
        end
        compared++;
        if (gb !== model_bcd(v) || gk !== model_blank(v) || gy !== 1'b1) begin
            mismatched++;
            $display("FAIL %s_result: bin=%0d bcd=%h blank=%b busy=%b required bcd=%h blank=%b busy=1",
                     name, v, gb, gk, gy, model_bcd(v), model_blank(v));
        end
        @(posedge CLK);
        #1;
        compared++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL %s_exit: done=%b busy=%b required 0 0", name, done, busy);
        end
        $display("convert %s: bin=%0d bcd=%h blank=%b latency=%0d", name, v, gb, gk, lat);
    endtask

    task automatic test_hold;
        logic [11:0] held;
        held = bcd;
        repeat (5) @(posedge CLK);
        #1;
        compared++;
        if (bcd !== held || bcd !== model_bcd(510) || done !== 1'b0) begin
            mismatched++;
            $display("FAIL hold_result: bcd=%h done=%b required bcd=%h done=0",
                     bcd, done, model_bcd(510));
        end
        $display("hold: bcd=%h after 5 idle cycles", bcd);
    endtask

    task automatic test_reset_mid_shift;
        int pulses;
        @(negedge CLK);
        start = 1'b1;
        bin   = WIDTH'(300);
        @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        reset_n = 1'b0;
        #1;
        compared++;
        if (busy !== 1'b0 || bcd !== '0 || done !== 1'b0 || blank !== '0) begin
            mismatched++;
            $display("FAIL reset_mid_shift: busy=%b bcd=%h done=%b blank=%b required all 0",
                     busy, bcd, done, blank);
        end
        @(negedge CLK);
        reset_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge CLK);
            #1;
            if (done === 1'b1) pulses++;
        end
        compared++;
        if (pulses != 0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_no_done: done pulses=%0d busy=%b required 0 0", pulses, busy);
        end
        $display("reset mid shift: stray done pulses=%0d", pulses);
        test_value("after_reset", 300);
    endtask

    task automatic test_ignore_start;
        int pulses;
        int first;
        logic [11:0] got;
        @(negedge CLK);
        start = 1'b1;
        bin   = WIDTH'(100);
        @(posedge CLK);
        #1;
        start = 1'b0;
        pulses = 0;
        first  = -1;
        got    = 'x;
        for (int c = 1; c <= 30; c++) begin
            if (c == 3) begin
                start = 1'b1;
                bin   = WIDTH'(7);
            end
            if (c == 6) start = 1'b0;
            @(posedge CLK);
            #1;
            if (done === 1'b1) begin
                pulses++;
                if (first < 0) begin
                    first = c;
                    got   = bcd;
                end
            end
        end
        compared++;
        if (pulses != 1 || first != LAT || got !== model_bcd(100)) begin
            mismatched++;
            $display("FAIL ignore_start: pulses=%0d at=%0d bcd=%h required 1 at %0d bcd=%h",
                     pulses, first, got, LAT, model_bcd(100));
        end
        $display("ignore start: pulses=%0d first at %0d bcd=%h", pulses, first, got);
    endtask

    task automatic test_back_to_back;
        int t[2];
        logic [11:0] r[2];
        logic [2:0]  k[2];
        logic        b10;
        int n;
        @(negedge CLK);
        start = 1'b1;
        bin   = WIDTH'(9);
        @(posedge CLK);
        #1;
        bin = WIDTH'(10);
        n = 0;
        b10 = 1'bx;
        t[0] = -1; t[1] = -1;
        r[0] = 'x; r[1] = 'x; k[0] = 'x; k[1] = 'x;
        for (int c = 1; c <= 35; c++) begin
            @(posedge CLK);
            #1;
            if (c == LAT + 1) begin
                start = 1'b0;
                b10   = busy;
            end
            if (done === 1'b1 && n < 2) begin
                t[n] = c;
                r[n] = bcd;
                k[n] = blank;
                n++;
            end
        end
        compared++;
        if (t[0] != LAT || t[1] != 2 * LAT + 1 || b10 !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_timing: done at %0d,%0d busy_between=%b required %0d,%0d busy 1",
                     t[0], t[1], b10, LAT, 2 * LAT + 1);
        end
        compared++;
        if (r[0] !== model_bcd(9) || k[0] !== model_blank(9) ||
            r[1] !== model_bcd(10) || k[1] !== model_blank(10)) begin
            mismatched++;
            $display("FAIL b2b_result: %h/%b then %h/%b required %h/%b then %h/%b",
                     r[0], k[0], r[1], k[1], model_bcd(9), model_blank(9),
                     model_bcd(10), model_blank(10));
        end
        $display("back to back: done at %0d and %0d results %h %h", t[0], t[1], r[0], r[1]);
    endtask

    task automatic test_random;
        int v;
        for (int i = 0; i < 20; i++) begin
            v = int'($urandom_range(510, 0));
            test_value("random", v);
        end
    endtask

    initial begin
        test_reset();
        test_value("zero", 0);
        test_value("max", 510);
        test_hold();
        test_value("ff", 255);
        test_value("seven", 7);
        test_value("ninety_nine", 99);
        test_reset_mid_shift();
        test_ignore_start();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
